control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 Run  input  1  start request, sampled in state T0 only.
REQ-005 IR  input  9  registered instruction, formatted as III XXX YYY: opcode IR[8:6], X=IR[5:3], Y=IR[2:0]; valid from T1 onward.
REQ-006 control  output  10  one-hot bus-mux select: bit9=DIN, bit8=R0 ... bit1=R7, bit0=G; R[k] maps to bit (8-k).
REQ-007 Rin  output  8  register write enables; bit k enables R[k].
REQ-008 IRin  output  1  instruction register load enable from DIN.
REQ-009 Ain  output  1  A operand register load enable from Bus.
REQ-010 Gin  output  1  G result register load enable from the ALU.
REQ-011 AddSub  output  1  ALU operation select: 0=add, 1=subtract.
REQ-012 Done  output  1  instruction-complete strobe, high for exactly one cycle per instruction.

Function
REQ-013 The block SHALL hold a 2-bit step register with states T0 (idle/fetch), T1, T2 and T3.
REQ-014 All outputs SHALL be combinational functions of the step register, IR and Run; the next step SHALL be registered.
REQ-015 control SHALL be all-zero or exactly one-hot in every cycle; it SHALL never have two bits set.
REQ-016 Every output not explicitly asserted for a step/opcode SHALL be 0.
REQ-017 T0: IRin=Run; if Run=1, next step=T1; otherwise stay in T0; control=0.
REQ-018 Opcode 000 (mv Rx,Ry), T1: control selects R[Y], Rin[X]=1, Done=1; next step=T0.
REQ-019 Opcode 001 (mvi Rx,#D), T1: control=DIN (bit9), Rin[X]=1, Done=1; next step=T0.
REQ-020 Opcodes 010 (add) and 011 (sub), T1: control selects R[X], Ain=1; next step=T2.
REQ-021 add/sub, T2: control selects R[Y], Gin=1, AddSub=IR[6]; next step=T3.
REQ-022 add/sub, T3: control=G (bit0), Rin[X]=1, Done=1; next step=T0.
REQ-023 Opcodes 1xx are reserved; in T1 the block SHALL assert only Done=1 and then return to T0.
REQ-024 Latency from the Run-sampled edge: mv, mvi and reserved opcodes complete in T1, 1 cycle later; add and sub complete in T3, 3 cycles later.
REQ-025 Run SHALL be ignored in T1-T3; a new instruction is accepted only in T0. Back-to-back instructions are allowed: Run=1 in the T0 that follows Done starts the next one.
REQ-026 X=Y is legal (e.g. add R3,R3); decoding SHALL not special-case it.
REQ-027 Rin SHALL have at most one bit set, and only in the Done cycle.

Reset
REQ-028 While Reset=1 at a rising edge, the step register SHALL become T0, overriding Run.
REQ-029 While Reset=1, all outputs SHALL be forced to 0, including IRin and Done.
REQ-030 Reset asserted mid-instruction (T1-T3) SHALL abandon the instruction: no Rin or Done is issued, and the block sits in T0 on the next cycle.
REQ-031 After Reset deasserts, the block SHALL accept Run on the first T0 cycle.

Verification
REQ-032 Reset=1 for 2 cycles with Run=1 -> step T0, all outputs 0, IRin=0 throughout.
REQ-033 T0 with Run=1 -> IRin=1; then IR=000_010_101 (mv R2,R5) -> T1: control=10'b0000001000, Rin=8'b00000100, Done=1; next cycle T0.
REQ-034 IR=001_111_000 (mvi R7) -> T1: control=10'b1000000000, Rin=8'b10000000, Done=1.
REQ-035 IR=011_001_011 (sub R1,R3) -> T1: control=10'b0010000000, Ain=1; T2: control=10'b0000100000, Gin=1, AddSub=1; T3: control=10'b0000000001, Rin=8'b00000010, Done=1.
REQ-036 add in progress, Reset=1 at T2 -> next cycle T0, Done and Rin never asserted; Run=1 afterwards starts a fresh fetch.
REQ-037 IR=110_000_000 followed by continuous Run=1 -> T1: Done=1 with all other outputs 0, then T0 with IRin=1; Run toggled during T1-T3 of an add has no effect on the sequence.

Source files
------------

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Multi-cycle control sequencer for a simple 9-bit-instruction
//             processor. A 2-bit step register walks T0 (idle/fetch) through
//             T1..T3. All control outputs are decoded combinationally from the
//             current step, the instruction register and Run.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock   in   1   rising-edge clock
//    Reset   in   1   synchronous, active-high; forces T0 and zeroes outputs
//    Run     in   1   start request, honoured only in T0
//    IR      in   9   instruction III XXX YYY (opcode, X, Y)
//    control out  10  one-hot bus select: bit9=DIN, bit(8-k)=R[k], bit0=G
//    Rin     out  8   register write enables, bit k -> R[k]
//    IRin    out  1   instruction register load enable
//    Ain     out  1   A operand register load enable
//    Gin     out  1   G result register load enable
//    AddSub  out  1   ALU op select, 0=add 1=sub
//    Done    out  1   one-cycle instruction-complete strobe
// ============================================================================
module control_unit (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] IR,
  output logic [9:0] control,
  output logic [7:0] Rin,
  output logic       IRin,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;

  step_t       step;
  step_t       step_next;

  logic [2:0]  opcode;
  logic [2:0]  reg_x;
  logic [2:0]  reg_y;
  logic        is_alu;

  assign opcode = IR[8:6];
  assign reg_x  = IR[5:3];
  assign reg_y  = IR[2:0];
  // add (010) and sub (011) share the three-step datapath sequence
  assign is_alu = (opcode[2:1] == 2'b01);

  // Bus select for register R[k]: register k lives at bit (8-k)
  function automatic logic [9:0] reg_sel(input logic [2:0] r);
    logic [9:0] sel;
    sel = '0;
    sel[4'd8 - {1'b0, r}] = 1'b1;
    return sel;
  endfunction

  function automatic logic [7:0] reg_en(input logic [2:0] r);
    logic [7:0] en;
    en = '0;
    en[r] = 1'b1;
    return en;
  endfunction

  always_comb begin
    step_next = step;
    control   = '0;
    Rin       = '0;
    IRin      = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AddSub    = 1'b0;
    Done      = 1'b0;

    case (step)
      T0: begin
        IRin      = Run;
        step_next = Run ? T1 : T0;
      end

      T1: begin
        step_next = T0;
        if (opcode == OP_MV) begin
          control = reg_sel(reg_y);
          Rin     = reg_en(reg_x);
          Done    = 1'b1;
        end else if (opcode == OP_MVI) begin
          control[9] = 1'b1;
          Rin        = reg_en(reg_x);
          Done       = 1'b1;
        end else if (is_alu) begin
          control   = reg_sel(reg_x);
          Ain       = 1'b1;
          step_next = T2;
        end else begin
          // reserved opcodes complete immediately with no side effects
          Done = 1'b1;
        end
      end

      T2: begin
        step_next = T0;
        if (is_alu) begin
          control   = reg_sel(reg_y);
          Gin       = 1'b1;
          AddSub    = IR[6];
          step_next = T3;
        end
      end

      T3: begin
        step_next = T0;
        if (is_alu) begin
          control[0] = 1'b1;
          Rin        = reg_en(reg_x);
          Done       = 1'b1;
        end
      end

      default: step_next = T0;
    endcase

    // Reset silences every output in the same cycle, abandoning any
    // instruction in flight before it can write a register or signal Done.
    if (Reset) begin
      control = '0;
      Rin     = '0;
      IRin    = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      AddSub  = 1'b0;
      Done    = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step <= T0;
    end else begin
      step <= step_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Self-checking bench for control_unit. A behavioural model tracks
//             whether an instruction is in flight and how many cycles of it
//             have elapsed, and derives the expected outputs from the
//             instruction semantics each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Run   = 1'b0;
  logic [8:0] IR    = '0;
  logic [9:0] control;
  logic [7:0] Rin;
  logic       IRin;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;

  control_unit dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Run     (Run),
    .IR      (IR),
    .control (control),
    .Rin     (Rin),
    .IRin    (IRin),
    .Ain     (Ain),
    .Gin     (Gin),
    .AddSub  (AddSub),
    .Done    (Done)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  // Model state: an instruction is in flight and this is its cycle number
  // (1 = first cycle after the fetch edge).
  bit busy = 1'b0;
  int cyc  = 0;

  logic [9:0] e_control;
  logic [7:0] e_rin;
  logic       e_irin, e_ain, e_gin, e_addsub, e_done;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  function automatic int inst_cycles(input logic [8:0] ir);
    return (ir[8:6] == 3'b010 || ir[8:6] == 3'b011) ? 3 : 1;
  endfunction

  // Expected outputs from the instruction semantics:
  //   mv   : cycle1 bus=R[y], write R[x], done
  //   mvi  : cycle1 bus=DIN, write R[x], done
  //   add/sub : cycle1 bus=R[x] into A; cycle2 bus=R[y] into G with op;
  //             cycle3 bus=G, write R[x], done
  //   reserved: cycle1 done only
  task automatic compute_expected(input logic rst, input logic run, input logic [8:0] ir);
    int op, x, y;
    op = int'(ir[8:6]);
    x  = int'(ir[5:3]);
    y  = int'(ir[2:0]);
    e_control = '0; e_rin = '0;
    e_irin = 0; e_ain = 0; e_gin = 0; e_addsub = 0; e_done = 0;
    if (rst) return;
    if (!busy) begin
      e_irin = run;
      return;
    end
    if (op == 0) begin
      e_control = 10'd1 << (8 - y);
      e_rin     = 8'd1 << x;
      e_done    = 1;
    end else if (op == 1) begin
      e_control = 10'd1 << 9;
      e_rin     = 8'd1 << x;
      e_done    = 1;
    end else if (op == 2 || op == 3) begin
      if (cyc == 1) begin
        e_control = 10'd1 << (8 - x);
        e_ain     = 1;
      end else if (cyc == 2) begin
        e_control = 10'd1 << (8 - y);
        e_gin     = 1;
        e_addsub  = (op == 3);
      end else begin
        e_control = 10'd1;
        e_rin     = 8'd1 << x;
        e_done    = 1;
      end
    end else begin
      e_done = 1;
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the
  // model and the clock.
  task automatic run_cycle(input logic rst, input logic run, input logic [8:0] ir);
    Reset = rst;
    Run   = run;
    IR    = ir;
    #4;
    compute_expected(rst, run, ir);
    check("control", control, e_control);
    check("Rin", {2'b00, Rin}, {2'b00, e_rin});
    check("IRin", {9'd0, IRin}, {9'd0, e_irin});
    check("Ain", {9'd0, Ain}, {9'd0, e_ain});
    check("Gin", {9'd0, Gin}, {9'd0, e_gin});
    check("AddSub", {9'd0, AddSub}, {9'd0, e_addsub});
    check("Done", {9'd0, Done}, {9'd0, e_done});
    check("control_onehot0", {9'd0, $onehot0(control)}, 10'd1);
    check("Rin_onehot0", {9'd0, $onehot0(Rin)}, 10'd1);
    if (rst) begin
      busy = 0;
    end else if (!busy) begin
      if (run) begin
        busy = 1;
        cyc  = 1;
      end
    end else if (cyc >= inst_cycles(ir)) begin
      busy = 0;
    end else begin
      cyc++;
    end
    @(posedge Clock);
    #1;
  endtask

  logic [8:0] held_ir;
  logic       r_rst, r_run;

  initial begin
    // Reset held for two cycles with Run asserted: nothing may be fetched
    run_cycle(1, 1, 9'b000_000_000);
    run_cycle(1, 1, 9'b000_000_000);

    // mv R2,R5
    run_cycle(0, 1, 9'b000_010_101);
    run_cycle(0, 0, 9'b000_010_101);
    run_cycle(0, 0, 9'b000_010_101);

    // mvi R7
    run_cycle(0, 1, 9'b001_111_000);
    run_cycle(0, 0, 9'b001_111_000);

    // sub R1,R3
    run_cycle(0, 1, 9'b011_001_011);
    run_cycle(0, 0, 9'b011_001_011);
    run_cycle(0, 0, 9'b011_001_011);
    run_cycle(0, 0, 9'b011_001_011);

    // add R4,R6 abandoned by reset in its T2, then a fresh fetch
    run_cycle(0, 1, 9'b010_100_110);
    run_cycle(0, 0, 9'b010_100_110);
    run_cycle(1, 0, 9'b010_100_110);
    run_cycle(0, 1, 9'b000_001_001);
    run_cycle(0, 0, 9'b000_001_001);

    // reserved opcode with Run held high, back-to-back into an add whose
    // middle cycles see Run toggling; X=Y add R3,R3
    run_cycle(0, 1, 9'b110_000_000);
    run_cycle(0, 1, 9'b110_000_000);
    run_cycle(0, 1, 9'b010_011_011);
    run_cycle(0, 0, 9'b010_011_011);
    run_cycle(0, 1, 9'b010_011_011);
    run_cycle(0, 0, 9'b010_011_011);
    run_cycle(0, 0, 9'b010_011_011);

    // Randomized traffic with occasional resets
    held_ir = '0;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 39) == 0);
      r_run = ($urandom_range(0, 2) != 0);
      if (!busy) held_ir = 9'($urandom);
      run_cycle(r_rst, r_run, held_ir);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
